sifive_reset_requester: RTL and testbench

SIFIVE_RESET_REQUESTER -- requirements
Module: sifive_reset_requester

---
 rtl/sifive_reset_pkg.sv | 29 ++
 rtl/sifive_reset_requester_if.sv | 24 ++
 rtl/sifive_bit_sync.sv | 20 ++
 rtl/sifive_reset_requester.sv | 132 +++++++++++++
 tb/tb_sifive_reset_requester.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sifive_reset_pkg.sv
// Shared state encodings, cause codes and helpers for the reset requester.
// Pure types and constant functions; no logic, no latency.
package sifive_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SW   = 2'd1,
    CAUSE_WDOG = 2'd2
  } cause_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Watchdog outranks software, whether fresh or already latched as pending.
  function automatic cause_e merge_cause(input logic   wdog,
                                         input logic   pend,
                                         input cause_e pend_cause);
    return (wdog || (pend && (pend_cause == CAUSE_WDOG))) ? CAUSE_WDOG : CAUSE_SW;
  endfunction

endpackage

// File: rtl/sifive_reset_requester_if.sv
// Request/acknowledge/status bundle between reset sources and the reset requester.
// Wires only; the slave side is the requester, the master side drives requests and acks.
interface sifive_reset_requester_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_req;
  logic                   wdog_req;
  logic [NUM_DOMAINS-1:0] ack;
  logic                   err_clr;
  logic                   areset;
  logic                   busy;
  logic [1:0]             cause;
  logic                   timeout_err;

  modport master (
    output sw_req, wdog_req, ack, err_clr,
    input  areset, busy, cause, timeout_err
  );

  modport slave (
    input  sw_req, wdog_req, ack, err_clr,
    output areset, busy, cause, timeout_err
  );
endinterface

// File: rtl/sifive_bit_sync.sv
// Two-flop synchronizer for one asynchronous status bit; 2-cycle latency, no backpressure.
// Resets to 0 so an unknown domain is treated as "not in reset".
module sifive_bit_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];
endmodule

// File: rtl/sifive_reset_requester.sv
// Sequences a POR/SW/WDOG reset through downstream domains: assert, hold, release with timeouts.
// areset rises one cycle after a request in IDLE; requests while busy are merged into one pending slot.
module sifive_reset_requester
  import sifive_reset_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                     clock,
  input logic                     reset_n,
  sifive_reset_requester_if.slave bus
);

  localparam int TW = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q;
  logic                   areset_q;
  cause_e                 cause_q;
  logic                   terr_q;
  logic                   pend_q;
  cause_e                 pend_cause_q;
  logic [NUM_DOMAINS-1:0] ack_sync;
  logic                   all_in;
  logic                   all_out;
  logic                   req_any;
  logic                   start;
  logic                   set_terr;
  cause_e                 start_cause;

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_sync
    sifive_bit_sync u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (bus.ack[i]),
      .q       (ack_sync[i])
    );
  end

  assign all_in  = &ack_sync;
  assign all_out = ~|ack_sync;
  assign req_any = bus.sw_req | bus.wdog_req | pend_q;

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    set_terr    = 1'b0;
    start_cause = merge_cause(bus.wdog_req, pend_q, pend_cause_q);
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_ASSERT;
          start   = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (all_in) begin
          state_d = ST_HOLD;
        end else if (timer_q == TO_LAST) begin
          state_d  = ST_HOLD;
          set_terr = 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (all_out) begin
          state_d = ST_IDLE;
        end else if (timer_q == TO_LAST) begin
          state_d  = ST_IDLE;
          set_terr = 1'b1;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ASSERT;
      timer_q  <= '0;
      areset_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      areset_q <= (state_d == ST_ASSERT) || (state_d == ST_HOLD);
      // Timer restarts on every state entry and saturates rather than wrapping.
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != TIMER_MAX) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cause_q      <= CAUSE_POR;
      terr_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_cause_q <= CAUSE_SW;
    end else begin
      if (start) begin
        cause_q <= start_cause;
      end
      if (set_terr) begin
        terr_q <= 1'b1;
      end else if (bus.err_clr) begin
        terr_q <= 1'b0;
      end
      // Any pending request is consumed by the IDLE->ASSERT start it triggers.
      if (state_q == ST_IDLE) begin
        pend_q <= 1'b0;
      end else if (bus.sw_req || bus.wdog_req) begin
        pend_q       <= 1'b1;
        pend_cause_q <= merge_cause(bus.wdog_req, pend_q, pend_cause_q);
      end
    end
  end

  assign bus.areset      = areset_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.cause       = cause_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sifive_reset_requester.sv
// Scoreboarded bench: each stimulus queues expected sequence records; a monitor measures each completed sequence.
// Domain model: every ack bit follows areset five cycles late unless forced stuck low.
module tb_sifive_reset_requester;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  sifive_reset_requester_if #(.NUM_DOMAINS(4)) bus ();

  sifive_reset_requester #(
    .NUM_DOMAINS    (4),
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int cause;
    int hi;
    int tl;
    int terr;
    int gap;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] stuck    = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_outstanding required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Domain model: acks trail areset by five cycles; cleared while reset_n is low.
  initial begin
    logic [7:0] hist;
    hist    = 8'h00;
    bus.ack = 4'h0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) hist = 8'h00;
      else          hist = {hist[6:0], bus.areset};
      bus.ack = hist[4] ? ~stuck : 4'h0;
    end
  end

  // Monitor: areset-high length, busy tail after areset falls, idle gap before start.
  initial begin
    int   hi, tl, idle, gap, nseq;
    logic prev_busy;
    exp_t e;
    hi = 0; tl = 0; idle = 0; gap = 0; nseq = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("areset_during_reset", bus.areset, 1);
        hi = 0; tl = 0; idle = 0; gap = 0;
        prev_busy = 1'b0;
      end else begin
        if (bus.areset) begin
          if (hi == 0) gap = idle;
          idle = 0;
          hi++;
        end else if (bus.busy) begin
          tl++;
        end else begin
          if (prev_busy) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_seq actual=cause%0d required=none", bus.cause);
            end else begin
              e = sb.pop_front();
              chk($sformatf("seq%0d_cause", nseq), bus.cause, e.cause);
              chk($sformatf("seq%0d_areset_len", nseq), hi, e.hi);
              chk($sformatf("seq%0d_tail_len", nseq), tl, e.tl);
              chk($sformatf("seq%0d_timeout_err", nseq), bus.timeout_err, e.terr);
              if (e.gap >= 0) chk($sformatf("seq%0d_gap", nseq), gap, e.gap);
            end
            nseq++;
            hi = 0;
            tl = 0;
          end
          idle++;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "tb time limit");
  end

  initial begin
    bus.sw_req   = 1'b0;
    bus.wdog_req = 1'b0;
    bus.err_clr  = 1'b0;
    #1 reset_n = 1'b0;
    cyc(3);
    chk("rst_areset", bus.areset, 1);
    chk("rst_busy", bus.busy, 1);
    chk("rst_cause", bus.cause, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);

    // Power-on sequence
    sb.push_back('{cause:0, hi:24, tl:7, terr:0, gap:0});
    reset_n = 1'b1;
    drain("por");

    // Software request: areset one cycle after sampling
    cyc(2);
    bus.sw_req = 1'b1;
    sb.push_back('{cause:1, hi:23, tl:7, terr:0, gap:-1});
    @(negedge clock);
    chk("sw_areset_before", bus.areset, 0);
    cyc(1);
    bus.sw_req = 1'b0;
    @(negedge clock);
    chk("sw_areset_rise", bus.areset, 1);
    chk("sw_cause_early", bus.cause, 1);
    drain("sw");

    // Simultaneous requests, then SW during HOLD becomes pending
    cyc(2);
    bus.sw_req   = 1'b1;
    bus.wdog_req = 1'b1;
    sb.push_back('{cause:2, hi:23, tl:7, terr:0, gap:-1});
    sb.push_back('{cause:1, hi:23, tl:7, terr:0, gap:1});
    cyc(1);
    bus.sw_req   = 1'b0;
    bus.wdog_req = 1'b0;
    cyc(12);
    bus.sw_req = 1'b1;
    cyc(1);
    bus.sw_req = 1'b0;
    drain("prio_pend");

    // Watchdog level held across a sequence yields a second one
    cyc(2);
    bus.wdog_req = 1'b1;
    sb.push_back('{cause:2, hi:23, tl:7, terr:0, gap:-1});
    sb.push_back('{cause:2, hi:23, tl:7, terr:0, gap:1});
    cyc(10);
    bus.wdog_req = 1'b0;
    drain("wdog_level");

    // Domain 2 never acknowledges: ASSERT times out after 64 cycles
    cyc(2);
    stuck      = 4'b0100;
    bus.sw_req = 1'b1;
    sb.push_back('{cause:1, hi:80, tl:7, terr:1, gap:-1});
    cyc(1);
    bus.sw_req = 1'b0;
    drain("timeout");
    cyc(3);
    chk("terr_sticky", bus.timeout_err, 1);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    @(negedge clock);
    chk("terr_cleared", bus.timeout_err, 0);
    stuck = 4'h0;

    // Reset during RELEASE aborts and reruns POR
    cyc(2);
    bus.sw_req = 1'b1;
    cyc(1);
    bus.sw_req = 1'b0;
    cyc(23);
    chk("mid_release_areset", bus.areset, 0);
    chk("mid_release_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_areset", bus.areset, 1);
    chk("mid_rst_busy", bus.busy, 1);
    chk("mid_rst_cause", bus.cause, 0);
    sb.push_back('{cause:0, hi:24, tl:7, terr:0, gap:0});
    cyc(3);
    reset_n = 1'b1;
    drain("mid_reset_por");

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
